xcore_exe_pshift: RTL and testbench
===================================

XCORE_EXE_PSHIFT -- requirements
Module: xcore_exe_pshift

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 8..64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 SHALL derive localparam SW = log2(WIDTH), the shift-amount width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous pipeline kill.
REQ-007 in_valid  input  1  operation offered.
REQ-008 in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-009 in_data  input  WIDTH  operand.
REQ-010 in_shamt  input  SW  shift amount, 0..WIDTH-1.
REQ-011 in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-012 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 out_data  output  WIDTH  shifted result.
REQ-016 out_cout  output  1  last bit shifted out.
REQ-017 out_tag  output  TAG_W  tag of the result.

Function
REQ-018 SHALL be a two-stage pipeline: stage A applies shift levels for in_shamt[SW/2-1:0] and registers partial data, remaining shamt bits, op, tag, cout; stage B applies the remaining levels and registers outputs.
REQ-019 SHALL have latency exactly 2 cycles from accept to out_valid, with no output stall.
REQ-020 SHALL sustain one accepted operation per cycle while out_ready is held high.
REQ-021 Stage B SHALL advance when !out_valid || out_ready; stage A SHALL advance when its valid is 0 or stage B advances.
REQ-022 in_ready SHALL equal the stage-A advance condition, combinationally, independent of in_valid.
REQ-023 While out_valid && !out_ready, out_data, out_cout and out_tag SHALL hold stable.
REQ-024 SLL SHALL zero-fill LSBs; SRL SHALL zero-fill MSBs; SRA SHALL fill MSBs with in_data[WIDTH-1]; ROR SHALL rotate right, bit i of the result taking in_data[(i+shamt) mod WIDTH].
REQ-025 out_cout SHALL be: SLL in_data[WIDTH-shamt]; SRL/SRA in_data[shamt-1]; ROR result bit WIDTH-1; 0 whenever shamt == 0.
REQ-026 shamt == 0 SHALL return in_data unchanged for every op.
REQ-027 flush SHALL clear both stage valids at the next edge, SHALL take priority over in_valid that cycle, and SHALL leave data registers unchanged.
REQ-028 A flushed operation SHALL never appear on the output; flush with pipeline empty SHALL be harmless.

Reset
REQ-029 rst_n low SHALL asynchronously clear both stage valids, out_data, out_cout and out_tag to 0.
REQ-030 in_ready SHALL be 1 during and immediately after reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result SHALL emerge after release.

Configuration
REQ-032 Macro XCORE_SHIFT_ROTATE_EN SHALL compile in the ROR datapath.
REQ-033 With XCORE_SHIFT_ROTATE_EN defined, in_op 11 SHALL perform ROR per REQ-024/REQ-025.
REQ-034 Without XCORE_SHIFT_ROTATE_EN, in_op 11 SHALL behave exactly as SRL and no rotate logic SHALL be synthesised.

Verification
REQ-035 WIDTH=32: SRA, in_data 0x8000_00F0, shamt 4 -> two cycles later out_data 0xF800_000F, out_cout 0.
REQ-036 SLL 0x8000_0001 shamt 1 -> 0x0000_0002, cout 1; SRL 0x0000_0003 shamt 1 -> 0x0000_0001, cout 1; any op, shamt 0 -> data unchanged, cout 0.
REQ-037 Macro on: ROR 0x0000_0001 shamt 1 -> 0x8000_0000, cout 1; macro off: same stimulus -> 0x0000_0000, cout 1.
REQ-038 Back-to-back tags 0..7 with out_ready low cycles 3-5 -> in_ready drops once both stages full, outputs held stable, all eight results emerge in order, none lost or duplicated.
REQ-039 Accept tags 1 and 2 on consecutive cycles, assert flush next cycle -> neither tag appears; tag 3 accepted after flush emerges two cycles later.
REQ-040 rst_n pulsed low with two operations in flight -> out_valid 0, out_data 0, in_ready 1 immediately; no result after release.

Source files
------------

// File: rtl/xcore_exe_pshift_if.sv
// Handshake bundle for the xcore pipelined shifter.
// master: operation source / result sink; slave: the shifter.
interface xcore_exe_pshift_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_cout, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_cout, out_tag
  );
endinterface

// File: rtl/xcore_exe_pshift.sv
// Two-stage barrel shifter: SLL/SRL/SRA (+ROR when XCORE_SHIFT_ROTATE_EN).
// Ports: clk, rst_n (async low), flush, io (xcore_exe_pshift_if.slave).
module xcore_exe_pshift #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  xcore_exe_pshift_if.slave  io
);
  localparam int SW = $clog2(WIDTH);
  localparam int LO = SW / 2;
  localparam int HI = SW - LO;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [HI-1:0]    hi;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic             cout;
  } stg_a_t;

  // One shift level of 2**k; returns {cout, data}.
  // The last applied level's cout is the overall last bit out.
  function automatic logic [WIDTH:0] lvl(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input int               k
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] t;
    logic             is_sll;
    logic             is_sra;
    logic             is_ror;
    int               s;
    s      = 1 << k;
    is_sll = (op == 2'b00);
    is_sra = (op == 2'b10);
`ifdef XCORE_SHIFT_ROTATE_EN
    is_ror = (op == 2'b11);
`else
    is_ror = 1'b0;
`endif
    r = d;
    t = d;
    unique case (1'b1)
      is_sll: begin
        r = d << s;
        t = d >> (WIDTH - s);
      end
      is_sra: begin
        r = $signed(d) >>> s;
        t = d >> (s - 1);
      end
      is_ror: begin
        r = (d >> s) | (d << (WIDTH - s));
        t = r >> (WIDTH - 1);
      end
      default: begin
        r = d >> s;
        t = d >> (s - 1);
      end
    endcase
    return {t[0], r};
  endfunction

  logic             a_valid;
  stg_a_t           a_q;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_cout;
  logic [TAG_W-1:0] b_tag;

  logic             adv_a;
  logic             adv_b;
  logic [WIDTH-1:0] a_d;
  logic             a_c;
  logic [WIDTH-1:0] b_d;
  logic             b_c;

  assign adv_b = !b_valid || io.out_ready;
  assign adv_a = !a_valid || adv_b;

  assign io.in_ready  = adv_a;
  assign io.out_valid = b_valid;
  assign io.out_data  = b_data;
  assign io.out_cout  = b_cout;
  assign io.out_tag   = b_tag;

  always_comb begin
    a_d = io.in_data;
    a_c = 1'b0;
    for (int k = 0; k < LO; k++) begin
      if (io.in_shamt[k]) begin
        {a_c, a_d} = lvl(a_d, io.in_op, k);
      end
    end
  end

  always_comb begin
    b_d = a_q.data;
    b_c = a_q.cout;
    for (int k = LO; k < SW; k++) begin
      if (a_q.hi[k-LO]) begin
        {b_c, b_d} = lvl(b_d, a_q.op, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_q     <= '0;
      b_valid <= 1'b0;
      b_data  <= '0;
      b_cout  <= 1'b0;
      b_tag   <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      if (adv_b) begin
        b_valid <= a_valid;
        if (a_valid) begin
          b_data <= b_d;
          b_cout <= b_c;
          b_tag  <= a_q.tag;
        end
      end
      if (adv_a) begin
        a_valid <= io.in_valid;
        if (io.in_valid) begin
          a_q.data <= a_d;
          a_q.hi   <= io.in_shamt[SW-1:LO];
          a_q.op   <= io.in_op;
          a_q.tag  <= io.in_tag;
          a_q.cout <= a_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_xcore_exe_pshift.sv
// Self-checking bench for xcore_exe_pshift.
// Random traffic against a scoreboard plus directed cases.
module tb_xcore_exe_pshift;
  localparam int W  = 32;
  localparam int TW = 4;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  xcore_exe_pshift_if #(.WIDTH(W), .TAG_W(TW)) io ();

  xcore_exe_pshift #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (io)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_out = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: {cout, result} from the shift rules directly.
  function automatic logic [W:0] ref_op(input logic [W-1:0] d,
                                        input int s,
                                        input logic [1:0] op);
    logic [W-1:0] r;
    logic [W-1:0] t;
    logic         c;
    bit           rot;
    rot = 1'b0;
`ifdef XCORE_SHIFT_ROTATE_EN
    rot = (op == 2'b11);
`endif
    if (op == 2'b00) r = d << s;
    else if (op == 2'b10) r = $signed(d) >>> s;
    else if (rot) r = (s == 0) ? d : ((d >> s) | (d << (W - s)));
    else r = d >> s;
    if (s == 0) c = 1'b0;
    else if (op == 2'b00) begin
      t = d >> (W - s);
      c = t[0];
    end else if (rot) c = r[W-1];
    else begin
      t = d >> (s - 1);
      c = t[0];
    end
    return {c, r};
  endfunction

  typedef struct {
    logic [W-1:0]  d;
    logic          c;
    logic [TW-1:0] t;
  } exp_t;

  exp_t q[$];

  logic          hold = 1'b0;
  logic [W-1:0]  hd;
  logic          hc;
  logic [TW-1:0] ht;

  always @(negedge clk) begin
    exp_t e;
    logic [W:0] rr;
    if (!rst_n) begin
      q.delete();
      hold = 1'b0;
    end else begin
      chk("in_ready", io.in_ready, (q.size() < 2) || io.out_ready);
      if (hold) begin
        chk("hold_data", io.out_data, hd);
        chk("hold_cout", io.out_cout, hc);
        chk("hold_tag", io.out_tag, ht);
      end
      hold = io.out_valid && !io.out_ready && !flush;
      hd = io.out_data;
      hc = io.out_cout;
      ht = io.out_tag;
      if (q.size() == 0) begin
        chk("orphan_valid", io.out_valid, 0);
      end else if (io.out_valid && io.out_ready) begin
        e = q.pop_front();
        n_out++;
        chk("out_data", io.out_data, e.d);
        chk("out_cout", io.out_cout, e.c);
        chk("out_tag", io.out_tag, e.t);
      end
      if (flush) q.delete();
      else if (io.in_valid && io.in_ready) begin
        rr = ref_op(io.in_data, int'(io.in_shamt), io.in_op);
        e.d = rr[W-1:0];
        e.c = rr[W];
        e.t = io.in_tag;
        q.push_back(e);
      end
    end
  end

  task automatic one(input logic [W-1:0] d, input logic [SW-1:0] s,
                     input logic [1:0] op, input logic [TW-1:0] t,
                     input logic [W-1:0] ed, input logic ec);
    @(posedge clk); #1;
    io.in_valid = 1'b1;
    io.in_data  = d;
    io.in_shamt = s;
    io.in_op    = op;
    io.in_tag   = t;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_valid", io.out_valid, 0);
    @(negedge clk);
    chk("lat2_valid", io.out_valid, 1);
    chk("dir_data", io.out_data, ed);
    chk("dir_cout", io.out_cout, ec);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      flush        = 1'b0;
    end
  endtask

  initial begin
    int sent;
    int base;
    bit stall;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_shamt  = '0;
    io.in_op     = '0;
    io.in_tag    = '0;
    io.out_ready = 1'b1;
    #2;
    chk("rst_ready", io.in_ready, 1);
    chk("rst_valid", io.out_valid, 0);
    chk("rst_data", io.out_data, 0);
    chk("rst_tag", io.out_tag, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_ready", io.in_ready, 1);

    one(32'h8000_00F0, 5'd4, 2'b10, 4'd1, 32'hF800_000F, 1'b0);
    one(32'h8000_0001, 5'd1, 2'b00, 4'd2, 32'h0000_0002, 1'b1);
    one(32'h0000_0003, 5'd1, 2'b01, 4'd3, 32'h0000_0001, 1'b1);
    for (int op = 0; op < 4; op++)
      one(32'hA5A5_1234, 5'd0, 2'(op), 4'd4, 32'hA5A5_1234, 1'b0);
`ifdef XCORE_SHIFT_ROTATE_EN
    one(32'h0000_0001, 5'd1, 2'b11, 4'd5, 32'h8000_0000, 1'b1);
`else
    one(32'h0000_0001, 5'd1, 2'b11, 4'd5, 32'h0000_0000, 1'b1);
`endif
    one(32'h0000_0003, 5'd31, 2'b00, 4'd6, 32'h8000_0000, 1'b1);
    one(32'h8000_0000, 5'd31, 2'b10, 4'd7, 32'hFFFF_FFFF, 1'b0);
    one(32'h8000_0000, 5'd31, 2'b01, 4'd8, 32'h0000_0001, 1'b0);
    idle(2);

    // back-to-back tags with a three-cycle output stall
    sent  = 0;
    stall = 1'b0;
    base  = n_out;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      io.out_ready = !(cyc >= 3 && cyc <= 5);
      io.in_valid  = (sent < 8);
      io.in_tag    = TW'(sent);
      io.in_data   = $urandom;
      io.in_shamt  = SW'($urandom);
      io.in_op     = 2'($urandom);
      @(negedge clk);
      if (!io.in_ready) stall = 1'b1;
      if (io.in_valid && io.in_ready) sent++;
    end
    idle(3);
    chk("b2b_stall_seen", stall, 1);
    chk("b2b_sent", sent, 8);
    chk("b2b_emerged", n_out - base, 8);
    chk("b2b_drain", q.size(), 0);

    // flush kills tags 1,2; flush on empty pipe beats in_valid
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.in_tag    = 4'd1;
    @(posedge clk); #1;
    io.in_tag    = 4'd2;
    @(posedge clk); #1;
    flush        = 1'b1;
    io.in_tag    = 4'd9;
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    flush        = 1'b0;
    io.in_tag    = 4'd3;
    @(posedge clk); #1;
    io.in_valid  = 1'b0;
    @(negedge clk);
    chk("flush_lat1", io.out_valid, 0);
    @(negedge clk);
    chk("flush_lat2", io.out_valid, 1);
    chk("flush_tag3", io.out_tag, 3);
    idle(3);

    // reset with two operations in flight
    @(posedge clk); #1;
    io.in_valid = 1'b1;
    io.in_data  = 32'h1234_5678;
    io.in_tag   = 4'd10;
    @(posedge clk); #1;
    io.in_tag   = 4'd11;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("mid_rst_valid", io.out_valid, 0);
    chk("mid_rst_data", io.out_data, 0);
    chk("mid_rst_ready", io.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base  = n_out;
    idle(6);
    chk("post_rst_none", n_out - base, 0);

    // random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      io.in_valid  = ($urandom % 4) != 0;
      io.out_ready = ($urandom % 4) != 0;
      flush        = ($urandom % 32) == 0;
      io.in_data   = $urandom;
      case ($urandom % 4)
        0: io.in_shamt = '0;
        1: io.in_shamt = '1;
        default: io.in_shamt = SW'($urandom);
      endcase
      io.in_op  = 2'($urandom);
      io.in_tag = TW'($urandom);
    end
    idle(5);
    chk("final_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
